// File: rtl/axi_sram_pkg.sv
// ----------------------------------------------------------------------------
// axi_sram_pkg
// Shared definitions for the AXI SRAM slave:
//   - one-hot state encodings for the read and write channel FSMs
//   - the AXI OKAY response code
//   - word_index(): converts a byte address into a word index
// No ports (package).
// ----------------------------------------------------------------------------
package axi_sram_pkg;

   typedef enum logic [2:0] {
      R_IDLE = 3'b001,
      R_RAM  = 3'b010,
      R_RESP = 3'b100
   } r_state_t;

   typedef enum logic [2:0] {
      W_IDLE = 3'b001,
      W_DATA = 3'b010,
      W_RESP = 3'b100
   } w_state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Drops the byte offset. The caller keeps only as many low bits as the RAM
   // is deep, which is what makes the upper address bits alias.
   function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
      return 30'(byte_addr >> 2);
   endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// ----------------------------------------------------------------------------
// axi_sram_slave_if
// AXI channel bundle between the CPU-side master bridge and axi_sram_slave.
// Parameter: ID_W - width of the AXI ID fields.
// Modports:
//   master - drives AR/AW/W and rready/bready, observes the rest
//   slave  - drives arready/awready/wready and the R/B channels
// ----------------------------------------------------------------------------
interface axi_sram_slave_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic            awvalid;
   logic            awready;

   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output arid, araddr, arlen, arsize, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/sram_1p_bw.sv
// ----------------------------------------------------------------------------
// sram_1p_bw
// Single-port synchronous word RAM with per-byte write enables and one cycle
// of read latency. Contents are not initialised.
// Parameter: DEPTH_W - address width; depth is 2**DEPTH_W 32-bit words.
// Ports:
//   clk   - clock
//   en    - access enable; rdata holds its value when low
//   we    - byte write enables; an enabled access with we == 0 is a read
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
module sram_1p_bw #(
   parameter int DEPTH_W = 14
) (
   input  logic               clk,
   input  logic               en,
   input  logic [3:0]         we,
   input  logic [DEPTH_W-1:0] addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata
);

   logic [31:0] mem [2**DEPTH_W];

   // rdata only changes on reads, so a write slipping in while the read FSM
   // waits to capture data cannot disturb the word it is about to return.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         if (we == 4'b0000) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/axi_sram_slave.sv
// ----------------------------------------------------------------------------
// axi_sram_slave
// AXI slave responder around a single-port byte-writable word RAM. Handles
// single-beat reads and writes with one outstanding transaction per
// direction; the write channel has priority for the shared RAM port.
// Parameters:
//   ADDR_W    - decoded byte-address bits (RAM depth 2**(ADDR_W-2) words;
//               higher address bits alias)
//   ID_W      - AXI ID width
//   LFSR_SEED - seed of the optional stall generator
// Ports:
//   aclk    - clock
//   aresetn - synchronous active-low reset
//   axi     - AXI channels (slave modport of axi_sram_slave_if)
// Build option: define AXI_SLAVE_RAND_STALL_EN to insert pseudo-random stalls
// on the ready outputs and before response entry (16-bit Galois LFSR).
// ----------------------------------------------------------------------------
module axi_sram_slave
   import axi_sram_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter int          ID_W      = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             aclk,
   input  logic             aresetn,
   axi_sram_slave_if.slave  axi
);

   localparam int DEPTH_W = ADDR_W - 2;

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;

   logic [ID_W-1:0]    rid_q;
   logic [ID_W-1:0]    bid_q;
   logic [31:0]        rdata_q;
   logic [DEPTH_W-1:0] w_idx_q;

   logic [29:0]        ar_word;
   logic [29:0]        aw_word;

   logic               ready_ok;
   logic               resp_ok;

   logic               arready_c, awready_c, wready_c;
   logic               ar_fire, aw_fire, w_fire;

   logic               ram_en;
   logic [3:0]         ram_we;
   logic [DEPTH_W-1:0] ram_addr;
   logic [31:0]        ram_rdata;

   logic               unused_bits;

`ifdef AXI_SLAVE_RAND_STALL_EN
   logic [15:0] lfsr;

   // Right-shifting Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign ready_ok = lfsr[0];
   assign resp_ok  = lfsr[1];
`else
   assign ready_ok = 1'b1;
   assign resp_ok  = 1'b1;
`endif

   assign ar_word = word_index(axi.araddr);
   assign aw_word = word_index(axi.awaddr);

   // A pending write beat blocks new reads so the two can never collide on
   // the RAM port. wready also waits on resp_ok because the write FSM has no
   // intermediate state in which to delay entry to W_RESP.
   assign arready_c = aresetn && ready_ok && (r_state == R_IDLE)
                      && !((w_state == W_DATA) && axi.wvalid);
   assign awready_c = aresetn && ready_ok && (w_state == W_IDLE);
   assign wready_c  = aresetn && ready_ok && resp_ok && (w_state == W_DATA);

   assign ar_fire = axi.arvalid && arready_c;
   assign aw_fire = axi.awvalid && awready_c;
   assign w_fire  = axi.wvalid  && wready_c;

   // An all-zero wstrb beat leaves the RAM idle; otherwise it would look
   // like a read and overwrite the RAM's read register.
   assign ram_en   = ar_fire || (w_fire && (axi.wstrb != 4'b0000));
   assign ram_we   = w_fire ? axi.wstrb : 4'b0000;
   assign ram_addr = w_fire ? w_idx_q : ar_word[DEPTH_W-1:0];

   sram_1p_bw #(
      .DEPTH_W (DEPTH_W)
   ) u_ram (
      .clk   (aclk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (axi.wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_fire)      r_next = R_RAM;
         R_RAM:   if (resp_ok)      r_next = R_RESP;
         R_RESP:  if (axi.rready)   r_next = R_IDLE;
         default:                   r_next = R_IDLE;
      endcase
   end

   // rdata_q keeps sampling while in R_RAM; the RAM output is frozen there,
   // so the value is the same however long a stall lasts.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         rid_q   <= '0;
         rdata_q <= '0;
      end else begin
         r_state <= r_next;
         if (ar_fire) begin
            rid_q <= axi.arid;
         end
         if (r_state == R_RAM) begin
            rdata_q <= ram_rdata;
         end
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_fire)      w_next = W_DATA;
         W_DATA:  if (w_fire)       w_next = W_RESP;
         W_RESP:  if (axi.bready)   w_next = W_IDLE;
         default:                   w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_state <= W_IDLE;
         bid_q   <= '0;
         w_idx_q <= '0;
      end else begin
         w_state <= w_next;
         if (aw_fire) begin
            bid_q   <= axi.awid;
            w_idx_q <= aw_word[DEPTH_W-1:0];
         end
      end
   end

   assign axi.arready = arready_c;
   assign axi.awready = awready_c;
   assign axi.wready  = wready_c;

   assign axi.rvalid  = (r_state == R_RESP);
   assign axi.rid     = rid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = RESP_OKAY;
   assign axi.rlast   = 1'b1;

   assign axi.bvalid  = (w_state == W_RESP);
   assign axi.bid     = bid_q;
   assign axi.bresp   = RESP_OKAY;

   // Burst/size/last fields and aliased address bits are deliberately ignored.
   assign unused_bits = ^{LFSR_SEED, axi.arlen, axi.arsize, axi.awlen,
                          axi.awsize, axi.wid, axi.wlast, ar_word, aw_word};

endmodule
